// File: rtl/tricpu_pkg.sv
// Shared types for the tricpu AXI-Stream input path: word width, the {last, data}
// stream word and the output-register state encoding.
package tricpu_pkg;

   localparam int AXIS_W = 32;

   typedef struct packed {
      logic              last;
      logic [AXIS_W-1:0] data;
   } axis_word_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port memory, synchronous write and registered read. A write to the
// address being read is forwarded so a freshly written head word is visible next cycle.
module sdp_ram #(
   parameter int P_WIDTH  = 33,
   parameter int P_ADDR_W = 4
) (
   input  logic                clk,
   input  logic                we,
   input  logic [P_ADDR_W-1:0] waddr,
   input  logic [P_WIDTH-1:0]  wdata,
   input  logic [P_ADDR_W-1:0] raddr,
   output logic [P_WIDTH-1:0]  rdata
);

   logic [P_WIDTH-1:0] mem [1 << P_ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axis_tx_fifo.sv
// Buffered AXI-Stream master feeding tricpu's s_axis port, with cut-through or
// store-and-forward release and occupancy/packet counters for debug.
module axis_tx_fifo
   import tricpu_pkg::*;
#(
   parameter int P_WIDTH      = AXIS_W,
   parameter int P_DEPTH_LOG2 = 4,
   parameter bit P_STORE_FWD  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [P_WIDTH-1:0]    wr_data,
   input  logic                  wr_last,
   output logic                  wr_ready,
   output logic [P_WIDTH-1:0]    m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [P_DEPTH_LOG2:0] o_level,
   output logic [P_DEPTH_LOG2:0] o_pkts,
   output logic                  o_overrun
);

   localparam int LW = P_DEPTH_LOG2 + 1;
   localparam logic [P_DEPTH_LOG2:0] LEVEL_FULL = LW'(1 << P_DEPTH_LOG2);

   typedef struct packed {
      logic               last;
      logic [P_WIDTH-1:0] data;
   } word_t;

   logic [P_DEPTH_LOG2:0] wr_ptr;
   logic [P_DEPTH_LOG2:0] rd_ptr;
   logic [P_DEPTH_LOG2:0] rd_ptr_next;
   logic [P_DEPTH_LOG2:0] level;
   logic [P_DEPTH_LOG2:0] pkts;
   logic                  in_prog;
   out_state_t            state;
   out_state_t            state_next;
   word_t                 wr_word;
   word_t                 rd_word;
   logic                  wr_en;
   logic                  load;
   logic                  load_slot;
   logic                  permit;
   logic                  handshake;
   logic                  mem_full;
   logic                  mem_empty;

   assign mem_full      = (level == LEVEL_FULL);
   assign mem_empty     = (level == '0);
   assign wr_ready      = !mem_full;
   assign wr_en         = wr_valid && wr_ready;
   assign wr_word       = {wr_last, wr_data};
   assign m_axis_tvalid = (state == OUT_FULL);
   assign handshake     = m_axis_tvalid && m_axis_tready;
   assign rd_ptr_next   = rd_ptr + LW'(load);
   assign o_level       = level;
   assign o_pkts        = pkts;

   // Reading at the next-head address keeps rd_word equal to the head word on every load edge.
   sdp_ram #(
      .P_WIDTH ($bits(word_t)),
      .P_ADDR_W(P_DEPTH_LOG2)
   ) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .waddr(wr_ptr[P_DEPTH_LOG2-1:0]),
      .wdata(wr_word),
      .raddr(rd_ptr_next[P_DEPTH_LOG2-1:0]),
      .rdata(rd_word)
   );

   // The full-memory escape lets packets longer than the buffer drain as cut-through.
   always_comb begin
      state_next = state;
      load_slot  = (state == OUT_EMPTY) || handshake;
      if (P_STORE_FWD) begin
         permit = !mem_empty && ((pkts != '0) || in_prog || mem_full);
      end else begin
         permit = !mem_empty;
      end
      load = load_slot && permit;
      if (load) begin
         state_next = OUT_FULL;
      end else if (handshake) begin
         state_next = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         pkts         <= '0;
         in_prog      <= 1'b0;
         o_overrun    <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tlast <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + LW'(1);
         end
         rd_ptr <= rd_ptr_next;
         level  <= level + LW'(wr_en) - LW'(load);
         pkts   <= pkts + LW'(wr_en && wr_last) - LW'(load && rd_word.last);
         if (load) begin
            m_axis_tdata <= rd_word.data;
            m_axis_tlast <= rd_word.last;
            in_prog      <= !rd_word.last;
         end
         if (wr_valid && !wr_ready) begin
            o_overrun <= 1'b1;
         end
      end
   end

   // The extra pointer MSB makes the pointer distance an independent copy of the level.
   ptr_level_consistent : assert property (@(posedge clk) disable iff (rst)
      (LW'(wr_ptr - rd_ptr) == level));

endmodule
